// File: rtl/reg_file_sb.sv
// GPR file with two combinational read ports, one write port, optional write-to-read
// bypass, a zeroing init sweep after reset and a per-register busy scoreboard.
module reg_file_sb #(
  parameter int unsigned REG_FILE_BITS = 5,
  parameter int unsigned REG_FILE_SIZE = 32,
  parameter int unsigned REG_SIZE      = 64,
  parameter bit          BYPASS        = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     ready,
  input  logic [REG_FILE_BITS-1:0] read_num1,
  input  logic [REG_FILE_BITS-1:0] read_num2,
  output logic [REG_SIZE-1:0]      out_reg1,
  output logic [REG_SIZE-1:0]      out_reg2,
  output logic                     pending1,
  output logic                     pending2,
  input  logic                     we,
  input  logic [REG_FILE_BITS-1:0] write_num,
  input  logic [REG_SIZE-1:0]      in_value,
  input  logic                     issue_valid,
  input  logic [REG_FILE_BITS-1:0] issue_rd,
  input  logic                     flush,
  output logic [REG_FILE_BITS:0]   busy_cnt
);

  localparam int unsigned CNT_W = REG_FILE_BITS + 1;
  localparam int unsigned IDX_W = (REG_FILE_SIZE > 1) ? $clog2(REG_FILE_SIZE) : 1;
  localparam logic [CNT_W-1:0]         SIZE_W   = CNT_W'(REG_FILE_SIZE);
  localparam logic [REG_FILE_BITS-1:0] LAST_IDX = REG_FILE_BITS'(REG_FILE_SIZE - 1);

  typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

  state_e                   state_q, state_d;
  logic                     sweep_we, run;
  logic [REG_FILE_BITS-1:0] sweep_q, sweep_d;
  logic [REG_FILE_SIZE-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]         busy_cnt_q, busy_cnt_d;
  logic [REG_SIZE-1:0]      mem_q [REG_FILE_SIZE];

  // Register 0 and indices beyond the file never hold state.
  function automatic logic idx_ok(input logic [REG_FILE_BITS-1:0] n);
    return (n != '0) && ({1'b0, n} < SIZE_W);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_INIT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT && sweep_q == LAST_IDX) state_d = ST_RUN;
  end

  always_comb begin
    sweep_we = 1'b0;
    run      = 1'b0;
    case (state_q)
      ST_INIT: sweep_we = 1'b1;
      ST_RUN:  run      = 1'b1;
      default: ;
    endcase
  end

  assign ready = run;

  // Sweep starts at 1: register 0 is hardwired and needs no clearing.
  assign sweep_d = sweep_we ? sweep_q + REG_FILE_BITS'(1) : sweep_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sweep_q <= REG_FILE_BITS'(1);
    else     sweep_q <= sweep_d;
  end

  logic             wr_ok, iss_ok, flush_ok;
  logic [IDX_W-1:0] wr_idx, iss_idx;
  logic             set_new, clr_old;

  assign wr_ok    = run && we && idx_ok(write_num);
  assign iss_ok   = run && issue_valid && idx_ok(issue_rd);
  assign flush_ok = run && flush;
  assign wr_idx   = IDX_W'(write_num);
  assign iss_idx  = IDX_W'(issue_rd);

  always_ff @(posedge clk) begin
    if (sweep_we)   mem_q[IDX_W'(sweep_q)] <= '0;
    else if (wr_ok) mem_q[wr_idx]          <= in_value;
  end

  // Count moves only on real 0->1 / 1->0 transitions; a same-register issue wins over the clear.
  assign set_new = iss_ok && !busy_q[iss_idx];
  assign clr_old = wr_ok && busy_q[wr_idx] && !(iss_ok && iss_idx == wr_idx);

  always_comb begin
    busy_d     = busy_q;
    busy_cnt_d = busy_cnt_q;
    if (flush_ok) begin
      busy_d     = '0;
      busy_cnt_d = '0;
    end else begin
      if (wr_ok)  busy_d[wr_idx]  = 1'b0;
      if (iss_ok) busy_d[iss_idx] = 1'b1;
      busy_cnt_d = busy_cnt_q + CNT_W'(set_new) - CNT_W'(clr_old);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      busy_cnt_q <= '0;
    end else begin
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
    end
  end

  assign busy_cnt = busy_cnt_q;

  logic             rd1_ok, rd2_ok, byp1, byp2;
  logic [IDX_W-1:0] rd1_idx, rd2_idx;

  assign rd1_ok  = run && idx_ok(read_num1);
  assign rd2_ok  = run && idx_ok(read_num2);
  assign rd1_idx = IDX_W'(read_num1);
  assign rd2_idx = IDX_W'(read_num2);
  assign byp1    = BYPASS && we && (write_num == read_num1);
  assign byp2    = BYPASS && we && (write_num == read_num2);

  always_comb begin
    out_reg1 = '0;
    out_reg2 = '0;
    if (rd1_ok) out_reg1 = byp1 ? in_value : mem_q[rd1_idx];
    if (rd2_ok) out_reg2 = byp2 ? in_value : mem_q[rd2_idx];
  end

  assign pending1 = rd1_ok && busy_q[rd1_idx] && !byp1;
  assign pending2 = rd2_ok && busy_q[rd2_idx] && !byp2;

endmodule

// File: tb/tb_reg_file_sb.sv
// Bench for reg_file_sb: a bypassing and a non-bypassing instance share stimulus and are
// compared every cycle against an array-based model of the register file and scoreboard.
module tb_reg_file_sb;

  localparam int unsigned BITS = 5;
  localparam int unsigned SIZE = 32;
  localparam int unsigned W    = 64;

  logic            clk;
  logic            rst;
  logic [BITS-1:0] read_num1, read_num2, write_num, issue_rd;
  logic [W-1:0]    in_value;
  logic            we, issue_valid, flush;

  logic            ready_b, pend1_b, pend2_b, ready_n, pend1_n, pend2_n;
  logic [W-1:0]    out1_b, out2_b, out1_n, out2_n;
  logic [BITS:0]   cnt_b, cnt_n;

  reg_file_sb #(.REG_FILE_BITS(BITS), .REG_FILE_SIZE(SIZE), .REG_SIZE(W), .BYPASS(1'b1)) u_dut_b (
    .clk(clk), .rst(rst), .ready(ready_b),
    .read_num1(read_num1), .read_num2(read_num2),
    .out_reg1(out1_b), .out_reg2(out2_b), .pending1(pend1_b), .pending2(pend2_b),
    .we(we), .write_num(write_num), .in_value(in_value),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush), .busy_cnt(cnt_b));

  reg_file_sb #(.REG_FILE_BITS(BITS), .REG_FILE_SIZE(SIZE), .REG_SIZE(W), .BYPASS(1'b0)) u_dut_n (
    .clk(clk), .rst(rst), .ready(ready_n),
    .read_num1(read_num1), .read_num2(read_num2),
    .out_reg1(out1_n), .out_reg2(out2_n), .pending1(pend1_n), .pending2(pend2_n),
    .we(we), .write_num(write_num), .in_value(in_value),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush), .busy_cnt(cnt_n));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: register contents, busy flags, remaining init-sweep cycles.
  logic [W-1:0] m_file [SIZE];
  bit           m_busy [SIZE];
  int           m_sweep_left;
  int           n_chk;
  int           n_fail;

  function automatic bit m_ready();
    return m_sweep_left == 0;
  endfunction

  task automatic model_reset();
    m_sweep_left = SIZE - 1;
    for (int r = 0; r < SIZE; r++) m_busy[r] = 1'b0;
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    if (!m_ready()) begin
      m_file[SIZE - m_sweep_left] = '0;
      m_sweep_left--;
      return;
    end
    for (int r = 1; r < SIZE; r++) begin
      if (flush)                                        m_busy[r] = 1'b0;
      else if (issue_valid && int'(issue_rd) == r)      m_busy[r] = 1'b1;
      else if (we && int'(write_num) == r)              m_busy[r] = 1'b0;
    end
    if (we && write_num != 0 && int'(write_num) < SIZE) m_file[write_num] = in_value;
  endtask

  function automatic logic [W-1:0] exp_out(input logic [BITS-1:0] n, input bit byp);
    if (!m_ready() || n == 0 || int'(n) >= SIZE) return '0;
    if (byp && we && write_num == n) return in_value;
    return m_file[n];
  endfunction

  function automatic logic exp_pend(input logic [BITS-1:0] n, input bit byp);
    if (!m_ready() || n == 0 || int'(n) >= SIZE) return 1'b0;
    return m_busy[n] && !(byp && we && write_num == n);
  endfunction

  function automatic int exp_cnt();
    int c = 0;
    for (int r = 0; r < SIZE; r++) c += int'(m_busy[r]);
    return c;
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    #1;
    chk("ready_b", W'(ready_b), W'(m_ready()));
    chk("ready_n", W'(ready_n), W'(m_ready()));
    chk("out1_b",  out1_b, exp_out(read_num1, 1'b1));
    chk("out2_b",  out2_b, exp_out(read_num2, 1'b1));
    chk("out1_n",  out1_n, exp_out(read_num1, 1'b0));
    chk("out2_n",  out2_n, exp_out(read_num2, 1'b0));
    chk("pend1_b", W'(pend1_b), W'(exp_pend(read_num1, 1'b1)));
    chk("pend2_b", W'(pend2_b), W'(exp_pend(read_num2, 1'b1)));
    chk("pend1_n", W'(pend1_n), W'(exp_pend(read_num1, 1'b0)));
    chk("pend2_n", W'(pend2_n), W'(exp_pend(read_num2, 1'b0)));
    chk("cnt_b",   W'(cnt_b), W'(exp_cnt()));
    chk("cnt_n",   W'(cnt_n), W'(exp_cnt()));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    model_step();
    #2;
  endtask

  task automatic drive_idle();
    we = 1'b0; write_num = '0; in_value = '0;
    issue_valid = 1'b0; issue_rd = '0; flush = 1'b0;
    read_num1 = '0; read_num2 = '0;
  endtask

  task automatic drive_random();
    we          = 1'($urandom_range(0, 1));
    write_num   = BITS'($urandom_range(0, SIZE - 1));
    in_value    = {$urandom, $urandom};
    issue_valid = ($urandom_range(0, 2) == 0);
    issue_rd    = BITS'($urandom_range(0, SIZE - 1));
    flush       = ($urandom_range(0, 39) == 0);
    read_num1   = ($urandom_range(0, 3) == 0) ? write_num : BITS'($urandom_range(0, SIZE - 1));
    read_num2   = ($urandom_range(0, 3) == 0) ? issue_rd  : BITS'($urandom_range(0, SIZE - 1));
  endtask

  // Counts sweep cycles until ready; noise drives writes/issues/flushes that must be ignored.
  task automatic wait_ready(input string name, input bit noise);
    int n = 0;
    while (ready_b !== 1'b1 && n < 100) begin
      next_cycle();
      if (noise && !m_ready()) drive_random();
      else                     drive_idle();
      check_all();
      n++;
    end
    chk(name, W'(n), W'(31));
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    drive_idle();
    rst = 1'b1;
    model_reset();
    check_all();
    next_cycle();
    next_cycle();
    rst = 1'b0;
    check_all();
    wait_ready("init_len", 1'b0);

    // Reset in the middle of a sweep restarts it from scratch.
    rst = 1'b1;
    model_reset();
    check_all();
    next_cycle();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      next_cycle();
      check_all();
    end
    rst = 1'b1;
    model_reset();
    check_all();
    next_cycle();
    rst = 1'b0;
    check_all();
    wait_ready("restart_len", 1'b1);

    for (int r = 0; r < SIZE; r++) begin
      next_cycle();
      drive_idle();
      read_num1 = BITS'(r);
      read_num2 = BITS'(SIZE - 1 - r);
      check_all();
      chk("zero_after_init", out1_b, 64'h0);
    end
    chk("busy_after_init", W'(cnt_b), W'(0));

    // Write / read back, and register 0 stays zero.
    next_cycle(); drive_idle();
    we = 1'b1; write_num = 5'd5; in_value = 64'hDEAD_BEEF_0000_0001;
    check_all();
    next_cycle(); drive_idle();
    read_num1 = 5'd5; read_num2 = 5'd5;
    check_all();
    chk("x5_port1", out1_n, 64'hDEAD_BEEF_0000_0001);
    chk("x5_port2", out2_b, 64'hDEAD_BEEF_0000_0001);
    next_cycle(); drive_idle();
    we = 1'b1; write_num = 5'd0; in_value = 64'h1234;
    check_all();
    next_cycle(); drive_idle();
    check_all();
    chk("x0_zero", out1_b, 64'h0);

    // Bypass versus stored value.
    next_cycle(); drive_idle();
    we = 1'b1; write_num = 5'd7; in_value = 64'h55;
    check_all();
    next_cycle(); drive_idle();
    we = 1'b1; write_num = 5'd7; in_value = 64'hAA; read_num1 = 5'd7;
    check_all();
    chk("bypass_on",  out1_b, 64'hAA);
    chk("bypass_off", out1_n, 64'h55);
    next_cycle(); drive_idle();
    read_num1 = 5'd7;
    check_all();
    chk("x7_after", out1_n, 64'hAA);

    // Scoreboard set/clear and same-cycle issue+write.
    next_cycle(); drive_idle(); issue_valid = 1'b1; issue_rd = 5'd3; check_all();
    next_cycle(); drive_idle(); issue_valid = 1'b1; issue_rd = 5'd4; check_all();
    next_cycle(); drive_idle(); read_num1 = 5'd3; check_all();
    chk("cnt_two", W'(cnt_b), W'(2));
    chk("pend_x3", W'(pend1_b), W'(1));
    next_cycle(); drive_idle();
    we = 1'b1; write_num = 5'd3; in_value = 64'h33; read_num1 = 5'd3;
    check_all();
    chk("pend_x3_byp",   W'(pend1_b), W'(0));
    chk("pend_x3_nobyp", W'(pend1_n), W'(1));
    next_cycle(); drive_idle(); read_num1 = 5'd3; check_all();
    chk("cnt_one", W'(cnt_b), W'(1));
    chk("pend_x3_clr", W'(pend1_b), W'(0));
    next_cycle(); drive_idle();
    issue_valid = 1'b1; issue_rd = 5'd4; we = 1'b1; write_num = 5'd4; in_value = 64'h44;
    check_all();
    next_cycle(); drive_idle(); read_num1 = 5'd4; check_all();
    chk("x4_still_busy", W'(pend1_b), W'(1));
    chk("cnt_still_one", W'(cnt_b), W'(1));
    chk("x4_value", out1_b, 64'h44);

    // Flush beats a same-cycle issue.
    next_cycle(); drive_idle(); issue_valid = 1'b1; issue_rd = 5'd1; check_all();
    next_cycle(); drive_idle(); issue_valid = 1'b1; issue_rd = 5'd2; check_all();
    next_cycle(); drive_idle(); issue_valid = 1'b1; issue_rd = 5'd9; check_all();
    next_cycle(); drive_idle(); read_num1 = 5'd9; check_all();
    chk("cnt_four", W'(cnt_b), W'(4));
    next_cycle(); drive_idle(); flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd10; check_all();
    next_cycle(); drive_idle(); read_num1 = 5'd10; check_all();
    chk("cnt_flushed", W'(cnt_n), W'(0));
    chk("x10_not_busy", W'(pend1_b), W'(0));

    for (int i = 0; i < 2000; i++) begin
      next_cycle();
      drive_random();
      check_all();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
